// File: rtl/sfu_pkg.sv
// Shared types and helpers for the vector special-function unit.
package sfu_pkg;

    typedef enum logic [1:0] {
        BYPASS = 2'b00,
        RELU   = 2'b01,
        LEAKY  = 2'b10,
        RSVD   = 2'b11
    } sfu_mode_t;

    localparam int LEAKY_SHIFT = 3;

    // Clamp a value known to fit in in_w signed bits into the signed out_w range.
    function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                               input int in_w, input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (in_w <= out_w) return value;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/sfu_out_fifo.sv
// Result FIFO with occupancy count; head is read combinationally from storage.
module sfu_out_fifo #(
    parameter int width = 128,
    parameter int depth = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [width-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [width-1:0]             rd_data,
    output logic [$clog2(depth):0]       count,
    output logic                         valid
);
    localparam int AW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign valid   = (count != '0);
    assign do_pop  = rd_en && valid;
    // A push into a full FIFO is only accepted when the head leaves on the same edge.
    assign do_push = wr_en && ((count < DEPTH_C) || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < depth; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sfu_vec.sv
// Multi-lane accumulate / activate / requantise unit with a handshaked output FIFO.
module sfu_vec
    import sfu_pkg::*;
#(
    parameter int col        = 8,
    parameter int psum_bw    = 16,
    parameter int acc_bw     = 24,
    parameter int fifo_depth = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [col*psum_bw-1:0]   in_data,
    input  logic [1:0]               mode,
    input  logic [3:0]               shift,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [col*psum_bw-1:0]   out_data
);
    localparam int DW = col * psum_bw;
    localparam int CW = $clog2(fifo_depth) + 1;

    logic            accept;
    logic            done;
    sfu_mode_t       mode_q;
    logic [3:0]      shift_q;
    logic [CW-1:0]   fifo_count;
    logic [DW-1:0]   post_data;

    // The pending result in done already owns a FIFO slot.
    assign in_ready = ({1'b0, fifo_count} + {{CW{1'b0}}, done}) < (CW+1)'(fifo_depth);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done    <= 1'b0;
            mode_q  <= BYPASS;
            shift_q <= '0;
        end else begin
            if (accept && in_last) begin
                done    <= 1'b1;
                mode_q  <= sfu_mode_t'(mode);
                shift_q <= shift;
            end else if (done) begin
                done <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < col; i++) begin : g_lane
        logic signed [psum_bw-1:0] beat;
        logic signed [acc_bw-1:0]  acc;
        logic                      clamped;
        logic signed [63:0]        sum_w;
        logic signed [63:0]        sum_c;
        logic signed [63:0]        act;
        logic signed [63:0]        res_w;

        assign beat = in_data[i*psum_bw +: psum_bw];

        always_comb begin
            sum_w = 64'(acc) + 64'(beat);
            sum_c = sat(sum_w, acc_bw + 1, acc_bw);
            case (mode_q)
                BYPASS:  act = 64'(acc);
                LEAKY:   act = acc[acc_bw-1] ? (64'(acc) >>> LEAKY_SHIFT) : 64'(acc);
                default: act = acc[acc_bw-1] ? 64'sd0 : 64'(acc);
            endcase
            res_w = sat(act >>> shift_q, acc_bw, psum_bw);
        end

        // On the done edge the finished sum leaves; a concurrent beat starts the next token.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                acc     <= '0;
                clamped <= 1'b0;
            end else if (done) begin
                acc     <= accept ? acc_bw'(beat) : '0;
                clamped <= 1'b0;
            end else if (accept && !clamped) begin
                acc     <= acc_bw'(sum_c);
                clamped <= (sum_c != sum_w);
            end
        end

        assign post_data[i*psum_bw +: psum_bw] = psum_bw'(res_w);
    end

    sfu_out_fifo #(
        .width (DW),
        .depth (fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (done),
        .wr_data (post_data),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .count   (fifo_count),
        .valid   (out_valid)
    );

endmodule

// File: tb/tb_sfu_vec.sv
// Scoreboard bench for sfu_vec: per-scenario tasks, reference model of accumulate/activate/requantise.
module tb_sfu_vec;
    localparam int COL   = 8;
    localparam int PW    = 16;
    localparam int ABW   = 24;
    localparam int DEPTH = 2;
    localparam int DW    = COL * PW;
    localparam longint AMAX = (longint'(1) <<< (ABW - 1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (ABW - 1));
    localparam longint PMAX = (longint'(1) <<< (PW - 1)) - 1;
    localparam longint PMIN = -(longint'(1) <<< (PW - 1));

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [DW-1:0] in_data;
    logic [1:0]    mode;
    logic [3:0]    shift;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [DW-1:0] exp_q   [$];
    logic [DW-1:0] beats_q [$];

    sfu_vec #(
        .col(COL), .psum_bw(PW), .acc_bw(ABW), .fifo_depth(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_data(in_data),
        .mode(mode), .shift(shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Output side of the scoreboard: every pop is checked against the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output got=%h want=<none>", out_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL out_data got=%h want=%h", out_data, e);
                end
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic last,
                             input logic [1:0] m, input logic [3:0] s);
        bit took;
        took     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        mode     = m;
        shift    = s;
        for (int k = 0; k < 200 && !took; k++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!took) begin
            n_cmp++;
            n_err++;
            $display("FAIL beat_accept_timeout in_ready=%b want=1", in_ready);
        end
    endtask

    // Sends every beat in beats_q as one token and queues the modelled result.
    task automatic send_token(input logic [1:0] m, input logic [3:0] s);
        longint        a  [COL];
        bit            cl [COL];
        logic [DW-1:0] d;
        logic [DW-1:0] ev;
        longint        x;
        int            n;
        n = beats_q.size();
        for (int l = 0; l < COL; l++) begin
            a[l]  = 0;
            cl[l] = 1'b0;
        end
        for (int b = 0; b < n; b++) begin
            d = beats_q[b];
            for (int l = 0; l < COL; l++) begin
                if (!cl[l]) begin
                    a[l] = a[l] + longint'($signed(d[l*PW +: PW]));
                    if (a[l] > AMAX) begin a[l] = AMAX; cl[l] = 1'b1; end
                    else if (a[l] < AMIN) begin a[l] = AMIN; cl[l] = 1'b1; end
                end
            end
            send_beat(d, (b == n - 1), m, s);
        end
        ev = '0;
        for (int l = 0; l < COL; l++) begin
            x = a[l];
            case (m)
                2'd0:    x = x;
                2'd2:    if (x < 0) x = x >>> 3;
                default: if (x < 0) x = 0;
            endcase
            x = x >>> s;
            if (x > PMAX) x = PMAX;
            if (x < PMIN) x = PMIN;
            ev[l*PW +: PW] = PW'(x);
        end
        exp_q.push_back(ev);
        beats_q.delete();
    endtask

    function automatic logic [DW-1:0] splat(input int v);
        logic [DW-1:0] r;
        for (int l = 0; l < COL; l++) r[l*PW +: PW] = PW'(v);
        return r;
    endfunction

    task automatic test_reset;
        reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        mode = 2'd0; shift = 4'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        beats_q.push_back(splat(5));
        send_token(2'd1, 4'd0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency_early got=%b want=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL latency_valid got=%b want=1", out_valid); end
        n_cmp++; if (out_data !== splat(5)) begin n_err++; $display("FAIL single_data got=%h want=%h", out_data, splat(5)); end
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL reset_drain pending=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_modes;
        logic [DW-1:0] d;
        int lane0 [3];
        lane0[0] = -40; lane0[1] = -40; lane0[2] = -48;
        out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            for (int b = 0; b < 3; b++) begin
                d = '0;
                d[0 +: PW] = PW'(lane0[b]);
                for (int l = 1; l < COL; l++) d[l*PW +: PW] = PW'(l * 1000 - 3500 + b * 17);
                beats_q.push_back(d);
            end
            send_token(2'(m), 4'd2);
        end
        for (int b = 0; b < 2; b++) begin
            d = '0;
            for (int l = 0; l < COL; l++) d[l*PW +: PW] = PW'((l - 4) * 9000);
            beats_q.push_back(d);
        end
        send_token(2'd2, 4'd1);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL modes_drain pending=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_saturation;
        logic [DW-1:0] d;
        out_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            d = '0;
            d[1*PW +: PW] = (pass == 0) ? 16'h7fff : 16'h8000;
            d[2*PW +: PW] = PW'(100);
            for (int b = 0; b < 300; b++) beats_q.push_back(d);
            send_token(2'd0, 4'd0);
        end
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sat_drain pending=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        beats_q.push_back(splat(1));
        send_token(2'd0, 4'd0);
        beats_q.push_back(splat(2));
        send_token(2'd0, 4'd0);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1 || out_data !== splat(1)) begin
                n_err++; $display("FAIL bp_head_stable got=%b/%h want=1/%h", out_valid, out_data, splat(1));
            end
        end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_in_ready got=%b want=0", in_ready); end
        out_ready = 1'b1;
        beats_q.push_back(splat(3));
        send_token(2'd0, 4'd0);
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_drain pending=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        int c0;
        out_ready = 1'b1;
        c0 = cyc;
        beats_q.push_back(splat(10));
        beats_q.push_back(splat(10));
        send_token(2'd0, 4'd0);
        beats_q.push_back(splat(7));
        beats_q.push_back(splat(7));
        send_token(2'd0, 4'd0);
        n_cmp++; if (cyc - c0 != 4) begin n_err++; $display("FAIL b2b_cycles got=%0d want=4", cyc - c0); end
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_drain pending=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        beats_q.push_back(splat(6));
        send_token(2'd0, 4'd0);
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ar_fifo_loaded got=%b want=1", out_valid); end
        send_beat(splat(9), 1'b0, 2'd0, 4'd0);
        send_beat(splat(9), 1'b0, 2'd0, 4'd0);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL ar_out_data got=%h want=0", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ar_in_ready got=%b want=1", in_ready); end
        exp_q.delete();
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        beats_q.push_back(splat(4));
        send_token(2'd0, 4'd0);
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ar_drain pending=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout time=%0t want=finish", $time);
        $fatal(1, "bench did not finish");
    end

endmodule
